axi_bram_port_arb: RTL and testbench

Shares a single physical BRAM port between the AXI-lite BRAM controller (port A, fixed latency, no back-pressure) and a second native requester (port B, valid/ready). Sits directly downstream of the AXI-lite-to-BRAM controller, in front of the BRAM macro. Port A always wins. Port B uses idle cycles, and its read data is returned through a credit-protected response FIFO.

---
 rtl/axi_bram_port_arb.sv | 115 +++++++++++
 tb/tb_axi_bram_port_arb.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_bram_port_arb.sv
// Shares one BRAM port between a fixed-latency priority master (A) and a valid/ready
// requester (B) whose read data returns through a credit-guarded response FIFO.
module axi_bram_port_arb #(
    parameter int DATA_WIDTH      = 64,
    parameter int BRAM_ADDR_WIDTH = 16,
    parameter int READ_LATENCY    = 1,
    parameter int RSP_DEPTH       = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         a_en,
    input  logic [DATA_WIDTH/8-1:0]      a_we,
    input  logic [BRAM_ADDR_WIDTH-1:0]   a_addr,
    input  logic [DATA_WIDTH-1:0]        a_wrdata,
    output logic [DATA_WIDTH-1:0]        a_rddata,
    input  logic                         b_req_valid,
    output logic                         b_req_ready,
    input  logic [DATA_WIDTH/8-1:0]      b_req_we,
    input  logic [BRAM_ADDR_WIDTH-1:0]   b_req_addr,
    input  logic [DATA_WIDTH-1:0]        b_req_wrdata,
    output logic                         b_rsp_valid,
    input  logic                         b_rsp_ready,
    output logic [DATA_WIDTH-1:0]        b_rsp_data,
    output logic                         bram_en,
    output logic [DATA_WIDTH/8-1:0]      bram_we,
    output logic [BRAM_ADDR_WIDTH-1:0]   bram_addr,
    output logic [DATA_WIDTH-1:0]        bram_wrdata,
    input  logic [DATA_WIDTH-1:0]        bram_rddata
);
    localparam int PTR_W = $clog2(RSP_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [READ_LATENCY-1:0] a_rd_p;
    logic [READ_LATENCY-1:0] b_rd_p;
    logic [DATA_WIDTH-1:0]   a_hold;
    logic [DATA_WIDTH-1:0]   rsp_mem [RSP_DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [CNT_W-1:0]        fifo_count;
    logic [CNT_W-1:0]        inflight;
    logic [CNT_W-1:0]        credit;
    logic                    b_fire;
    logic                    a_ret;
    logic                    b_ret;
    logic                    rsp_pop;

    // Credit reserves a FIFO slot for every B read still travelling through the BRAM.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + CNT_W'(b_rd_p[i]);
        end
    end

    assign credit      = CNT_W'(RSP_DEPTH) - fifo_count - inflight;
    assign b_req_ready = !a_en && ((b_req_we != '0) || (credit != '0));
    assign b_fire      = b_req_valid && b_req_ready;

    assign bram_en     = a_en || b_fire;
    assign bram_we     = a_en ? a_we : (b_fire ? b_req_we : '0);
    assign bram_addr   = a_en ? a_addr : b_req_addr;
    assign bram_wrdata = a_en ? a_wrdata : b_req_wrdata;

    assign a_ret       = a_rd_p[READ_LATENCY-1];
    assign b_ret       = b_rd_p[READ_LATENCY-1];
    assign a_rddata    = a_ret ? bram_rddata : a_hold;

    assign b_rsp_valid = (fifo_count != '0);
    assign b_rsp_data  = rsp_mem[rd_ptr];
    assign rsp_pop     = b_rsp_valid && b_rsp_ready;

    // Tag pipeline: stage 0 is the issue cycle, the last stage lines up with bram_rddata.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_rd_p <= '0;
            b_rd_p <= '0;
            a_hold <= '0;
        end else begin
            a_rd_p[0] <= a_en && (a_we == '0);
            b_rd_p[0] <= b_fire && (b_req_we == '0);
            for (int i = 1; i < READ_LATENCY; i++) begin
                a_rd_p[i] <= a_rd_p[i-1];
                b_rd_p[i] <= b_rd_p[i-1];
            end
            if (a_ret) begin
                a_hold <= bram_rddata;
            end
        end
    end

    // Response FIFO: the credit check guarantees a free slot for every push.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) begin
                rsp_mem[i] <= '0;
            end
        end else begin
            if (b_ret) begin
                rsp_mem[wr_ptr] <= bram_rddata;
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end
            if (rsp_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({b_ret, rsp_pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_bram_port_arb.sv
// Bench for axi_bram_port_arb: one instance at READ_LATENCY=1/RSP_DEPTH=4, one at
// READ_LATENCY=3/RSP_DEPTH=8, each in front of a behavioural BRAM.
module tb_axi_bram_port_arb;
    localparam int DW  = 64;
    localparam int AW  = 16;
    localparam int WEW = DW / 8;
    localparam int L1  = 1;

    logic clk = 1'b0;
    logic rst;
    logic mem_clear;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    logic           a_en, b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready, bram_en;
    logic [WEW-1:0] a_we, b_req_we, bram_we;
    logic [AW-1:0]  a_addr, b_req_addr, bram_addr;
    logic [DW-1:0]  a_wrdata, a_rddata, b_req_wrdata, b_rsp_data, bram_wrdata, bram_rddata;

    logic           s_a_en, s_b_req_valid, s_b_req_ready, s_b_rsp_valid, s_b_rsp_ready, s_bram_en;
    logic [WEW-1:0] s_a_we, s_b_req_we, s_bram_we;
    logic [AW-1:0]  s_a_addr, s_b_req_addr, s_bram_addr;
    logic [DW-1:0]  s_a_wrdata, s_a_rddata, s_b_req_wrdata, s_b_rsp_data, s_bram_wrdata, s_bram_rddata;

    axi_bram_port_arb #(.DATA_WIDTH(DW), .BRAM_ADDR_WIDTH(AW), .READ_LATENCY(L1), .RSP_DEPTH(4)) u_dut1 (
        .clk(clk), .rst(rst),
        .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_wrdata(a_wrdata), .a_rddata(a_rddata),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
        .b_req_addr(b_req_addr), .b_req_wrdata(b_req_wrdata),
        .b_rsp_valid(b_rsp_valid), .b_rsp_ready(b_rsp_ready), .b_rsp_data(b_rsp_data),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_wrdata(bram_wrdata), .bram_rddata(bram_rddata)
    );

    axi_bram_port_arb #(.DATA_WIDTH(DW), .BRAM_ADDR_WIDTH(AW), .READ_LATENCY(3), .RSP_DEPTH(8)) u_dut3 (
        .clk(clk), .rst(rst),
        .a_en(s_a_en), .a_we(s_a_we), .a_addr(s_a_addr), .a_wrdata(s_a_wrdata), .a_rddata(s_a_rddata),
        .b_req_valid(s_b_req_valid), .b_req_ready(s_b_req_ready), .b_req_we(s_b_req_we),
        .b_req_addr(s_b_req_addr), .b_req_wrdata(s_b_req_wrdata),
        .b_rsp_valid(s_b_rsp_valid), .b_rsp_ready(s_b_rsp_ready), .b_rsp_data(s_b_rsp_data),
        .bram_en(s_bram_en), .bram_we(s_bram_we), .bram_addr(s_bram_addr),
        .bram_wrdata(s_bram_wrdata), .bram_rddata(s_bram_rddata)
    );

    // Behavioural BRAMs, read-first, 256 words each.
    logic [DW-1:0] mem1 [256];
    logic [DW-1:0] mem3 [256];
    logic [DW-1:0] pipe3_0, pipe3_1;

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 256; i++) mem1[i] <= '0;
        end else if (bram_en) begin
            for (int b = 0; b < WEW; b++)
                if (bram_we[b]) mem1[bram_addr[7:0]][8*b +: 8] <= bram_wrdata[8*b +: 8];
        end
        bram_rddata <= mem1[bram_addr[7:0]];
    end

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 256; i++) mem3[i] <= '0;
        end else if (s_bram_en) begin
            for (int b = 0; b < WEW; b++)
                if (s_bram_we[b]) mem3[s_bram_addr[7:0]][8*b +: 8] <= s_bram_wrdata[8*b +: 8];
        end
        pipe3_0       <= mem3[s_bram_addr[7:0]];
        pipe3_1       <= pipe3_0;
        s_bram_rddata <= pipe3_1;
    end

    function automatic logic [DW-1:0] pat(input int k);
        return {32'hA5A5_0000 + 32'(k), 32'(k) * 32'h0101_0101};
    endfunction

    task automatic idle1();
        a_en = 1'b0; a_we = '0; a_addr = '0; a_wrdata = '0;
        b_req_valid = 1'b0; b_req_we = '0; b_req_addr = '0; b_req_wrdata = '0;
        b_rsp_ready = 1'b1;
    endtask

    task automatic idle3();
        s_a_en = 1'b0; s_a_we = '0; s_a_addr = '0; s_a_wrdata = '0;
        s_b_req_valid = 1'b0; s_b_req_we = '0; s_b_req_addr = '0; s_b_req_wrdata = '0;
        s_b_rsp_ready = 1'b1;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        idle1(); idle3(); rst = 1'b1; mem_clear = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; mem_clear = 1'b0;
        @(negedge clk);
        total++; if (b_rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got %b want 0", b_rsp_valid); end
        total++; if (b_rsp_data !== '0) begin bad++; $display("FAIL rst_rsp_data got %h want 0", b_rsp_data); end
        total++; if (a_rddata !== '0) begin bad++; $display("FAIL rst_a_rddata got %h want 0", a_rddata); end
        total++; if (b_req_ready !== 1'b1) begin bad++; $display("FAIL rst_req_ready got %b want 1", b_req_ready); end
        total++; if (bram_en !== 1'b0) begin bad++; $display("FAIL rst_bram_en got %b want 0", bram_en); end
        total++; if (s_b_rsp_valid !== 1'b0) begin bad++; $display("FAIL rst3_rsp_valid got %b want 0", s_b_rsp_valid); end
        total++; if (s_b_req_ready !== 1'b1) begin bad++; $display("FAIL rst3_req_ready got %b want 1", s_b_req_ready); end
        @(posedge clk); #1;
        a_en = 1'b1;
        @(negedge clk);
        total++; if (b_req_ready !== 1'b0) begin bad++; $display("FAIL rst_req_ready_a got %b want 0", b_req_ready); end
        total++; if (bram_en !== 1'b1) begin bad++; $display("FAIL rst_bram_en_a got %b want 1", bram_en); end
    endtask

    task automatic test_a_read();
        @(posedge clk); #1;
        idle1(); a_en = 1'b1; a_we = '1; a_addr = 16'd5; a_wrdata = 64'h1122;
        @(negedge clk);
        total++; if (bram_we !== 8'hFF) begin bad++; $display("FAIL ard_wr_we got %h want ff", bram_we); end
        total++; if (bram_addr !== 16'd5) begin bad++; $display("FAIL ard_wr_addr got %h want 5", bram_addr); end
        total++; if (bram_wrdata !== 64'h1122) begin bad++; $display("FAIL ard_wr_data got %h want 1122", bram_wrdata); end
        @(posedge clk); #1;
        a_we = '0;
        @(negedge clk);
        total++; if (bram_we !== 8'h00) begin bad++; $display("FAIL ard_rd_we got %h want 0", bram_we); end
        @(posedge clk); #1;
        a_en = 1'b0;
        @(negedge clk);
        total++; if (a_rddata !== 64'h1122) begin bad++; $display("FAIL ard_data got %h want 1122", a_rddata); end
        total++; if (b_rsp_valid !== 1'b0) begin bad++; $display("FAIL ard_b_quiet got %b want 0", b_rsp_valid); end
        total++; if (bram_en !== 1'b0) begin bad++; $display("FAIL ard_bus_idle got %b want 0", bram_en); end
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (a_rddata !== 64'h1122) begin bad++; $display("FAIL ard_hold got %h want 1122", a_rddata); end
    endtask

    task automatic test_contention();
        @(posedge clk); #1;
        idle1();
        b_req_valid = 1'b1; b_req_we = '1; b_req_addr = 16'd7; b_req_wrdata = 64'hC0FFEE;
        a_en = 1'b1; a_addr = 16'd5; a_wrdata = 64'hDEAD;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            @(negedge clk);
            total++; if (b_req_ready !== 1'b0) begin bad++; $display("FAIL cont_ready k=%0d got %b want 0", k, b_req_ready); end
            total++; if (bram_addr !== 16'd5 || bram_we !== 8'h00 || bram_wrdata !== 64'hDEAD) begin
                bad++; $display("FAIL cont_bus k=%0d got %h/%h/%h want 5/00/dead", k, bram_addr, bram_we, bram_wrdata);
            end
        end
        @(posedge clk); #1;
        a_en = 1'b0;
        @(negedge clk);
        total++; if (b_req_ready !== 1'b1) begin bad++; $display("FAIL cont_fire got %b want 1", b_req_ready); end
        total++; if (bram_en !== 1'b1 || bram_we !== 8'hFF || bram_addr !== 16'd7 || bram_wrdata !== 64'hC0FFEE) begin
            bad++; $display("FAIL cont_b_bus got %b/%h/%h/%h want 1/ff/7/c0ffee", bram_en, bram_we, bram_addr, bram_wrdata);
        end
        total++; if (a_rddata !== 64'h1122) begin bad++; $display("FAIL cont_a_data got %h want 1122", a_rddata); end
        @(posedge clk); #1;
        b_req_valid = 1'b0; a_en = 1'b1; a_we = '0; a_addr = 16'd7;
        @(posedge clk); #1;
        a_en = 1'b0;
        @(negedge clk);
        total++; if (a_rddata !== 64'hC0FFEE) begin bad++; $display("FAIL cont_b_write got %h want c0ffee", a_rddata); end
    endtask

    task automatic test_a_hold();
        @(posedge clk); #1;
        idle1(); a_en = 1'b1; a_we = '1; a_addr = 16'd1; a_wrdata = 64'hAA;
        @(posedge clk); #1;
        a_addr = 16'd2; a_wrdata = 64'hBB;
        @(posedge clk); #1;
        a_we = '0; a_addr = 16'd1;
        @(posedge clk); #1;
        a_en = 1'b0; b_req_valid = 1'b1; b_req_we = '0; b_req_addr = 16'd2;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin @(posedge clk); #1; b_req_valid = 1'b0; end
            @(negedge clk);
            total++; if (a_rddata !== 64'hAA) begin bad++; $display("FAIL hold_a k=%0d got %h want aa", k, a_rddata); end
            total++; if (b_rsp_valid !== (k == 2)) begin bad++; $display("FAIL hold_b_valid k=%0d got %b want %b", k, b_rsp_valid, k == 2); end
            if (k == 2) begin
                total++; if (b_rsp_data !== 64'hBB) begin bad++; $display("FAIL hold_b_data got %h want bb", b_rsp_data); end
            end
        end
    endtask

    task automatic test_backpressure();
        int fires;
        logic [DW-1:0] exp_d [4];
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            idle1(); a_en = 1'b1; a_we = '1; a_addr = AW'(10 + k); a_wrdata = 64'h100 + 64'(10 + k);
        end
        fires = 0;
        for (int c = 0; c < 7; c++) begin
            @(posedge clk); #1;
            idle1(); b_rsp_ready = 1'b0; b_req_valid = 1'b1; b_req_addr = AW'(10 + fires);
            @(negedge clk);
            if (b_req_ready === 1'b1) fires++;
            total++; if (b_req_ready !== (c < 4)) begin bad++; $display("FAIL bp_ready c=%0d got %b want %b", c, b_req_ready, c < 4); end
        end
        total++; if (fires !== 4) begin bad++; $display("FAIL bp_fires got %0d want 4", fires); end
        @(posedge clk); #1;
        b_req_we = '1; b_req_addr = 16'd20; b_req_wrdata = 64'h2020;
        @(negedge clk);
        total++; if (b_req_ready !== 1'b1) begin bad++; $display("FAIL bp_write_zero_credit got %b want 1", b_req_ready); end
        @(posedge clk); #1;
        b_req_we = '0; b_req_addr = 16'd14; b_rsp_ready = 1'b1;
        @(negedge clk);
        total++; if (b_req_ready !== 1'b0) begin bad++; $display("FAIL bp_pop_cycle_ready got %b want 0", b_req_ready); end
        total++; if (b_rsp_valid !== 1'b1 || b_rsp_data !== 64'h10A) begin bad++; $display("FAIL bp_rsp0 got %b/%h want 1/10a", b_rsp_valid, b_rsp_data); end
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (b_req_ready !== 1'b1) begin bad++; $display("FAIL bp_refire got %b want 1", b_req_ready); end
        total++; if (b_rsp_valid !== 1'b1 || b_rsp_data !== 64'h10B) begin bad++; $display("FAIL bp_rsp1 got %b/%h want 1/10b", b_rsp_valid, b_rsp_data); end
        exp_d[0] = 64'h10C; exp_d[1] = 64'h10D; exp_d[2] = 64'h10E; exp_d[3] = '0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            b_req_valid = 1'b0;
            @(negedge clk);
            total++; if (b_rsp_valid !== (k < 3)) begin bad++; $display("FAIL bp_drain_valid k=%0d got %b want %b", k, b_rsp_valid, k < 3); end
            if (k < 3) begin
                total++; if (b_rsp_data !== exp_d[k]) begin bad++; $display("FAIL bp_drain_data k=%0d got %h want %h", k, b_rsp_data, exp_d[k]); end
            end
        end
    endtask

    task automatic test_random(input int n);
        logic [DW-1:0] rmem [16];
        logic [DW-1:0] aq_d [$];
        int            aq_c [$];
        logic [DW-1:0] rq_d [$];
        int            rq_c [$];
        logic [DW-1:0] hold_exp, a_exp;
        logic [WEW-1:0] exp_we;
        logic          exp_ready, fire, exp_valid;
        int            outstanding;
        for (int i = 0; i < 16; i++) rmem[i] = '0;
        hold_exp = '0; outstanding = 0;
        @(posedge clk); #1;
        idle1(); rst = 1'b1; mem_clear = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; mem_clear = 1'b0;
        for (int c = 0; c < n; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            a_en         = ($urandom_range(0, 2) == 0);
            a_we         = ($urandom_range(0, 1) == 0) ? '0 : WEW'($urandom);
            a_addr       = AW'($urandom_range(0, 15));
            a_wrdata     = {$urandom, $urandom};
            b_req_valid  = ($urandom_range(0, 3) != 0);
            b_req_we     = ($urandom_range(0, 2) == 0) ? WEW'($urandom) : '0;
            b_req_addr   = AW'($urandom_range(0, 15));
            b_req_wrdata = {$urandom, $urandom};
            b_rsp_ready  = ($urandom_range(0, 1) == 0);
            @(negedge clk);
            exp_ready = !a_en && (b_req_we != '0 || outstanding < 4);
            fire      = b_req_valid && exp_ready;
            exp_we    = a_en ? a_we : (fire ? b_req_we : '0);
            total++; if (b_req_ready !== exp_ready) begin bad++; $display("FAIL rnd_ready c=%0d got %b want %b", c, b_req_ready, exp_ready); end
            total++; if (bram_en !== (a_en || fire)) begin bad++; $display("FAIL rnd_en c=%0d got %b want %b", c, bram_en, a_en || fire); end
            total++; if (bram_we !== exp_we) begin bad++; $display("FAIL rnd_we c=%0d got %h want %h", c, bram_we, exp_we); end
            total++; if (bram_addr !== (a_en ? a_addr : b_req_addr)) begin bad++; $display("FAIL rnd_addr c=%0d got %h", c, bram_addr); end
            total++; if (bram_wrdata !== (a_en ? a_wrdata : b_req_wrdata)) begin bad++; $display("FAIL rnd_wrdata c=%0d got %h", c, bram_wrdata); end
            a_exp = hold_exp;
            if (aq_c.size() > 0 && aq_c[0] == c) begin
                a_exp = aq_d.pop_front(); void'(aq_c.pop_front()); hold_exp = a_exp;
            end
            total++; if (a_rddata !== a_exp) begin bad++; $display("FAIL rnd_a_rddata c=%0d got %h want %h", c, a_rddata, a_exp); end
            exp_valid = (rq_c.size() > 0) && (rq_c[0] <= c);
            total++; if (b_rsp_valid !== exp_valid) begin bad++; $display("FAIL rnd_rsp_valid c=%0d got %b want %b", c, b_rsp_valid, exp_valid); end
            if (exp_valid) begin
                total++; if (b_rsp_data !== rq_d[0]) begin bad++; $display("FAIL rnd_rsp_data c=%0d got %h want %h", c, b_rsp_data, rq_d[0]); end
                if (b_rsp_ready) begin
                    void'(rq_d.pop_front()); void'(rq_c.pop_front()); outstanding--;
                end
            end
            if (a_en) begin
                if (a_we != '0) begin
                    for (int b = 0; b < WEW; b++) if (a_we[b]) rmem[a_addr[3:0]][8*b +: 8] = a_wrdata[8*b +: 8];
                end else begin
                    aq_d.push_back(rmem[a_addr[3:0]]); aq_c.push_back(c + L1);
                end
            end else if (fire) begin
                if (b_req_we != '0) begin
                    for (int b = 0; b < WEW; b++) if (b_req_we[b]) rmem[b_req_addr[3:0]][8*b +: 8] = b_req_wrdata[8*b +: 8];
                end else begin
                    rq_d.push_back(rmem[b_req_addr[3:0]]); rq_c.push_back(c + L1 + 1); outstanding++;
                end
            end
        end
        @(posedge clk); #1;
        idle1();
    endtask

    task automatic test_stream();
        logic exp_v;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk); #1;
            idle3(); s_b_req_valid = 1'b1; s_b_req_we = '1; s_b_req_addr = AW'(k); s_b_req_wrdata = pat(k);
            @(negedge clk);
            total++; if (s_b_req_ready !== 1'b1) begin bad++; $display("FAIL st_wr_ready k=%0d got %b want 1", k, s_b_req_ready); end
        end
        @(posedge clk); #1;
        idle3(); s_a_en = 1'b1; s_a_addr = 16'd2;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            s_a_en = 1'b0;
            @(negedge clk);
            total++; if (s_a_rddata !== ((k == 3) ? pat(2) : 64'h0)) begin
                bad++; $display("FAIL st_a_latency k=%0d got %h want %h", k, s_a_rddata, (k == 3) ? pat(2) : 64'h0);
            end
        end
        for (int j = 0; j < 22; j++) begin
            @(posedge clk); #1;
            s_b_req_valid = (j < 16); s_b_req_we = '0; s_b_req_addr = AW'(j);
            @(negedge clk);
            if (j < 16) begin
                total++; if (s_b_req_ready !== 1'b1) begin bad++; $display("FAIL st_rd_ready j=%0d got %b want 1", j, s_b_req_ready); end
            end
            exp_v = (j >= 4) && (j < 20);
            total++; if (s_b_rsp_valid !== exp_v) begin bad++; $display("FAIL st_valid j=%0d got %b want %b", j, s_b_rsp_valid, exp_v); end
            if (exp_v) begin
                total++; if (s_b_rsp_data !== pat(j - 4)) begin bad++; $display("FAIL st_data j=%0d got %h want %h", j, s_b_rsp_data, pat(j - 4)); end
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            idle3(); s_b_rsp_ready = 1'b0; s_b_req_valid = 1'b1; s_b_req_addr = AW'(3 + k);
            @(negedge clk);
            total++; if (s_b_req_ready !== 1'b1) begin bad++; $display("FAIL rm_fire k=%0d got %b want 1", k, s_b_req_ready); end
        end
        @(posedge clk); #1;
        s_b_req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        total++; if (s_b_rsp_valid !== 1'b1 || s_b_rsp_data !== pat(3)) begin
            bad++; $display("FAIL rm_pre got %b/%h want 1/%h", s_b_rsp_valid, s_b_rsp_data, pat(3));
        end
        @(posedge clk); #1;
        rst = 1'b0; s_b_rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            @(negedge clk);
            total++; if (s_b_rsp_valid !== 1'b0) begin bad++; $display("FAIL rm_stale k=%0d got %b want 0", k, s_b_rsp_valid); end
        end
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            s_b_rsp_ready = 1'b0; s_b_req_valid = 1'b1; s_b_req_we = '0; s_b_req_addr = AW'(c);
            @(negedge clk);
            total++; if (s_b_req_ready !== (c < 8)) begin bad++; $display("FAIL rm_credit c=%0d got %b want %b", c, s_b_req_ready, c < 8); end
        end
        for (int k = 0; k < 9; k++) begin
            @(posedge clk); #1;
            s_b_req_valid = 1'b0; s_b_rsp_ready = 1'b1;
            @(negedge clk);
            total++; if (s_b_rsp_valid !== (k < 8)) begin bad++; $display("FAIL rm_drain_valid k=%0d got %b want %b", k, s_b_rsp_valid, k < 8); end
            if (k < 8) begin
                total++; if (s_b_rsp_data !== pat(k)) begin bad++; $display("FAIL rm_drain_data k=%0d got %h want %h", k, s_b_rsp_data, pat(k)); end
            end
        end
    endtask

    initial begin
        rst = 1'b1; mem_clear = 1'b1;
        idle1(); idle3();
        test_reset();
        test_a_read();
        test_contention();
        test_a_hold();
        test_backpressure();
        test_random(400);
        test_stream();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
